// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that owns the d/e pins of a shared D-latch bank and sequences each write as setup, enable pulse, hold, ack.
// Defining LATCH_READBACK_CHECK_EN builds a q-versus-d compare in HOLD that drives the sticky err flag.
module latch_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int EN_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DW-1:0]     wdata,
    output logic [N_REQ-1:0]        ack,
    output logic [DW-1:0]           lat_d,
    output logic                    lat_e,
    input  logic [DW-1:0]           lat_q,
    output logic                    busy,
    output logic [2:0]              grant_id,
    output logic                    err
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ENABLE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] EN_LAST = 4'(EN_CYCLES - 1);
    localparam logic [2:0] ID_LAST = 3'(N_REQ - 1);

    state_t           state, state_nx;
    logic [3:0]       en_cnt, en_cnt_nx;
    logic [2:0]       rr_ptr, rr_ptr_nx;
    logic [2:0]       grant_id_nx;
    logic [DW-1:0]    lat_d_nx;
    logic [N_REQ-1:0] ack_nx;
    logic             lat_e_nx;
    logic             busy_nx;

    // Pad the per-requester data out to 8 slots so a 3-bit id indexes it cleanly.
    logic [DW-1:0] wdata_arr [8];

    genvar g;
    for (g = 0; g < 8; g++) begin : g_wdata
        if (g < N_REQ) begin : g_used
            assign wdata_arr[g] = wdata[g*DW +: DW];
        end else begin : g_pad
            assign wdata_arr[g] = '0;
        end
    end

    logic [N_REQ-1:0] at_or_after_ptr;
    logic [N_REQ-1:0] req_hi;
    logic [2:0]       hi_id;
    logic [2:0]       lo_id;
    logic [2:0]       pick_id;
    logic             pick_valid;

    // Round-robin pick: lowest set bit at or above the pointer, else lowest set bit overall (wrap).
    always_comb begin
        at_or_after_ptr = '0;
        hi_id           = '0;
        lo_id           = '0;
        for (int i = 0; i < N_REQ; i++) begin
            at_or_after_ptr[i] = (3'(i) >= rr_ptr);
        end
        req_hi = req & at_or_after_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_hi[i]) hi_id = 3'(i);
            if (req[i])    lo_id = 3'(i);
        end
        pick_valid = |req;
        pick_id    = (|req_hi) ? hi_id : lo_id;
    end

    always_comb begin
        state_nx    = state;
        en_cnt_nx   = en_cnt;
        rr_ptr_nx   = rr_ptr;
        grant_id_nx = grant_id;
        lat_d_nx    = lat_d;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_nx    = S_SETUP;
                    grant_id_nx = pick_id;
                    lat_d_nx    = wdata_arr[pick_id];
                end
            end
            S_SETUP: begin
                state_nx  = S_ENABLE;
                en_cnt_nx = EN_LAST;
            end
            S_ENABLE: begin
                if (en_cnt == 4'd0) begin
                    state_nx = S_HOLD;
                end else begin
                    en_cnt_nx = en_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx  = S_IDLE;
                rr_ptr_nx = (grant_id == ID_LAST) ? 3'd0 : grant_id + 3'd1;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so every pin leaves a flop.
        lat_e_nx = (state_nx == S_ENABLE);
        busy_nx  = (state_nx != S_IDLE);
        ack_nx   = (state_nx == S_DONE) ? (N_REQ'(1) << grant_id_nx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            en_cnt   <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
            lat_d    <= '0;
            ack      <= '0;
            lat_e    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            en_cnt   <= en_cnt_nx;
            rr_ptr   <= rr_ptr_nx;
            grant_id <= grant_id_nx;
            lat_d    <= lat_d_nx;
            ack      <= ack_nx;
            lat_e    <= lat_e_nx;
            busy     <= busy_nx;
        end
    end

`ifdef LATCH_READBACK_CHECK_EN
    // The bank was transparent during ENABLE, so in HOLD q must already equal d.
    logic err_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (state == S_HOLD && lat_q != lat_d) begin
            err_r <= 1'b1;
        end
    end
    assign err = err_r;
`else
    logic unused_lat_q;
    assign unused_lat_q = ^lat_q;
    assign err          = 1'b0;
`endif

    a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
    a_ack_only_done: assert property (@(posedge clk) disable iff (rst) (ack != '0) |-> (state == S_DONE));

endmodule
